// File: rtl/fx_addsub_pipe.sv
// rtl/fx_addsub_pipe.sv - multi-lane fixed-point add/sub with rescale, range handling and valid/ready pipeline
module fx_addsub_pipe #(
  parameter int LANES   = 1,
  parameter int W_IN    = 12,
  parameter int F_IN    = 4,
  parameter int W_OUT   = 13,
  parameter int F_OUT   = 4,
  parameter int LATENCY = 2,
  parameter int SAT     = 0,
  parameter int ROUND   = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_sub,
  input  logic [LANES*W_IN-1:0]  i_data_1,
  input  logic [LANES*W_IN-1:0]  i_data_2,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*W_OUT-1:0] o_data,
  output logic [LANES-1:0]       o_ovf,
  output logic                   o_ovf_sticky,
  input  logic                   i_ovf_clr
);

  // Left shift when gaining fraction bits, right shift when dropping them; one of the two is always 0.
  localparam int SHL     = (F_OUT >= F_IN) ? F_OUT - F_IN : 0;
  localparam int SHR     = (F_OUT < F_IN) ? F_IN - F_OUT : 0;
  localparam int RND_POS = (SHR > 0) ? SHR - 1 : 0;
  // Working width: exact sum (+1), rounding carry (+1), left shift growth, and room to compare against W_OUT limits.
  localparam int WA      = W_IN + 2 + SHL;
  localparam int WS      = (WA > W_OUT + 1) ? WA : W_OUT + 1;

  localparam logic signed [WS-1:0] RND_ADD =
    (ROUND != 0 && SHR > 0) ? ({{(WS-1){1'b0}}, 1'b1} << RND_POS) : {WS{1'b0}};
  localparam logic signed [WS-1:0] MAX_V = {{(WS-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [WS-1:0] MIN_V = ~MAX_V;
  localparam logic [W_OUT-1:0] SAT_MAX = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic [W_OUT-1:0] SAT_MIN = ~SAT_MAX;

  logic                   adv;
  logic [LANES*W_OUT-1:0] nxt_data;
  logic [LANES-1:0]       nxt_ovf;
  logic signed [WS-1:0]   a_x;
  logic signed [WS-1:0]   b_x;
  logic signed [WS-1:0]   s;
  logic                   lane_ovf;

  logic [LATENCY-1:0]     st_v;
  logic [LANES*W_OUT-1:0] st_d [LATENCY];
  logic [LANES-1:0]       st_o [LATENCY];

  // Every stage moves together whenever the output slot is free or being drained.
  assign adv     = !o_valid || i_ready;
  assign o_ready = i_rst_n && adv;
  assign o_valid = st_v[LATENCY-1];
  assign o_data  = st_d[LATENCY-1];
  assign o_ovf   = st_o[LATENCY-1];

  // Per-lane exact add/sub, rescale to the output fraction, then range check with wrap or clamp.
  always_comb begin
    nxt_data = '0;
    nxt_ovf  = '0;
    a_x      = '0;
    b_x      = '0;
    s        = '0;
    lane_ovf = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      a_x = {{(WS-W_IN){i_data_1[k*W_IN+W_IN-1]}}, i_data_1[k*W_IN +: W_IN]};
      b_x = {{(WS-W_IN){i_data_2[k*W_IN+W_IN-1]}}, i_data_2[k*W_IN +: W_IN]};
      s   = i_sub ? (a_x - b_x) : (a_x + b_x);
      s   = (s + RND_ADD) >>> SHR;
      s   = s <<< SHL;
      lane_ovf   = (s > MAX_V) || (s < MIN_V);
      nxt_ovf[k] = lane_ovf;
      if (lane_ovf && SAT != 0) begin
        nxt_data[k*W_OUT +: W_OUT] = s[WS-1] ? SAT_MIN : SAT_MAX;
      end else begin
        nxt_data[k*W_OUT +: W_OUT] = s[W_OUT-1:0];
      end
    end
  end

  // Pipeline: valids shift on every advance (bubbles too); data only loads behind a valid so outputs hold last beat.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        st_d[i] <= '0;
        st_o[i] <= '0;
      end
    end else if (adv) begin
      st_v[0] <= i_valid;
      if (i_valid) begin
        st_d[0] <= nxt_data;
        st_o[0] <= nxt_ovf;
      end
      for (int i = 1; i < LATENCY; i++) begin
        st_v[i] <= st_v[i-1];
        if (st_v[i-1]) begin
          st_d[i] <= st_d[i-1];
          st_o[i] <= st_o[i-1];
        end
      end
    end
  end

  // Sticky overflow: any delivered beat with an overflowing lane sets it; setting takes priority over clearing.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ovf_sticky <= 1'b0;
    end else if (o_valid && i_ready && (|o_ovf)) begin
      o_ovf_sticky <= 1'b1;
    end else if (i_ovf_clr) begin
      o_ovf_sticky <= 1'b0;
    end
  end

endmodule
